// File: rtl/aes_kat_pkg.sv
// Shared types and FIPS-197 known-answer constants for the AES KAT self-test engine.
package aes_kat_pkg;

    typedef struct packed {
        logic         encdec;
        logic         keylen;
        logic         reuse_key;
        logic [255:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } kat_vec_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_INIT_PULSE,
        ST_INIT_WAIT,
        ST_NEXT_PULSE,
        ST_NEXT_WAIT,
        ST_CHECK,
        ST_DONE
    } kat_state_t;

    localparam logic KEYLEN_128 = 1'b0;
    localparam logic KEYLEN_256 = 1'b1;
    localparam logic ENC        = 1'b1;
    localparam logic DEC        = 1'b0;

    // 128-bit keys live in the upper half of the 256-bit key bus
    localparam logic [255:0] KEY_128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT      = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    localparam int KAT_TABLE_SIZE = 4;

    function automatic kat_vec_t kat_entry(input logic [1:0] sel);
        kat_vec_t v;
        case (sel)
            2'd0:    v = '{encdec: ENC, keylen: KEYLEN_128, reuse_key: 1'b0,
                           key: KEY_128, pt: PT, ct: CT_128};
            2'd1:    v = '{encdec: DEC, keylen: KEYLEN_128, reuse_key: 1'b1,
                           key: KEY_128, pt: PT, ct: CT_128};
            2'd2:    v = '{encdec: ENC, keylen: KEYLEN_256, reuse_key: 1'b0,
                           key: KEY_256, pt: PT, ct: CT_256};
            default: v = '{encdec: DEC, keylen: KEYLEN_256, reuse_key: 1'b1,
                           key: KEY_256, pt: PT, ct: CT_256};
        endcase
        return v;
    endfunction

endpackage

// File: rtl/aes_kat_rom.sv
// Combinational KAT vector table; indices beyond the table wrap modulo its size.
module aes_kat_rom
    import aes_kat_pkg::*;
#(
    parameter int IDX_W = 2
) (
    input  logic [IDX_W-1:0] i_idx,
    output kat_vec_t         o_vec
);

    logic [1:0] w_sel;

    assign w_sel = 2'(32'(i_idx) % KAT_TABLE_SIZE);

    always_comb begin
        o_vec = kat_entry(w_sel);
    end

endmodule

// File: rtl/aes_kat_bist.sv
// Known-answer self-test engine: walks the KAT table through the AES core's
// init/next/ready handshake, checks each result and flags hangs.
module aes_kat_bist
    import aes_kat_pkg::*;
#(
    parameter int NUM_VECTORS    = 4,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int HOLDOFF        = 2,
    parameter int IDX_W          = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1,
    parameter int CNT_W          = $clog2(NUM_VECTORS + 1)
) (
    input  logic              ICLK,
    input  logic              IRST,
    input  logic              ISTART,
    output logic              OBUSY,
    output logic              ODONE,
    output logic              OPASS,
    output logic              OTIMEOUT,
    output logic [CNT_W-1:0]  OERR_CNT,
    output logic [IDX_W-1:0]  OFAIL_IDX,
    output logic              OAES_ENCDEC,
    output logic              OAES_INIT,
    output logic              OAES_NEXT,
    input  logic              IAES_READY,
    output logic [255:0]      OAES_KEY,
    output logic              OAES_KEYLEN,
    output logic [127:0]      OAES_BLOCK,
    input  logic [127:0]      IAES_RESULT,
    input  logic              IAES_RESULT_VALID
);

    // One down-counter covers holdoff followed by the timeout window
    localparam int TMR_LOAD = HOLDOFF + TIMEOUT_CYCLES;
    localparam int TMR_W    = $clog2(TMR_LOAD + 1);

    kat_state_t       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [TMR_W-1:0] r_timer;
    logic [127:0]     r_expected;

    kat_vec_t         w_vec;
    logic             w_holdoff;
    logic             w_timer_tc;
    logic             w_ready_ok;
    logic             w_mismatch;
    logic             w_last;
    logic [CNT_W-1:0] w_err_next;

    aes_kat_rom #(
        .IDX_W (IDX_W)
    ) u_rom (
        .i_idx (r_idx),
        .o_vec (w_vec)
    );

    assign w_holdoff  = r_timer > TMR_W'(TIMEOUT_CYCLES);
    assign w_timer_tc = r_timer == TMR_W'(1);
    assign w_ready_ok = (r_state == ST_NEXT_WAIT) ? (IAES_READY && IAES_RESULT_VALID)
                                                  : IAES_READY;
    assign w_mismatch = IAES_RESULT != r_expected;
    assign w_last     = r_idx == IDX_W'(NUM_VECTORS - 1);
    assign w_err_next = (OERR_CNT == '1) ? OERR_CNT : OERR_CNT + 1'b1;

    always_ff @(posedge ICLK) begin
        if (IRST) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_timer     <= '0;
            r_expected  <= '0;
            OBUSY       <= 1'b0;
            ODONE       <= 1'b0;
            OPASS       <= 1'b0;
            OTIMEOUT    <= 1'b0;
            OERR_CNT    <= '0;
            OFAIL_IDX   <= '0;
            OAES_ENCDEC <= 1'b0;
            OAES_INIT   <= 1'b0;
            OAES_NEXT   <= 1'b0;
            OAES_KEY    <= '0;
            OAES_KEYLEN <= 1'b0;
            OAES_BLOCK  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (ISTART) begin
                        r_state   <= ST_FETCH;
                        r_idx     <= '0;
                        OBUSY     <= 1'b1;
                        ODONE     <= 1'b0;
                        OPASS     <= 1'b0;
                        OTIMEOUT  <= 1'b0;
                        OERR_CNT  <= '0;
                        OFAIL_IDX <= '0;
                    end
                end
                ST_FETCH: begin
                    r_expected  <= w_vec.encdec ? w_vec.ct : w_vec.pt;
                    OAES_ENCDEC <= w_vec.encdec;
                    OAES_KEYLEN <= w_vec.keylen;
                    OAES_KEY    <= w_vec.key;
                    OAES_BLOCK  <= w_vec.encdec ? w_vec.pt : w_vec.ct;
                    if (w_vec.reuse_key && (r_idx != '0)) begin
                        r_state   <= ST_NEXT_PULSE;
                        OAES_NEXT <= 1'b1;
                    end else begin
                        r_state   <= ST_INIT_PULSE;
                        OAES_INIT <= 1'b1;
                    end
                end
                ST_INIT_PULSE: begin
                    OAES_INIT <= 1'b0;
                    r_timer   <= TMR_W'(TMR_LOAD);
                    r_state   <= ST_INIT_WAIT;
                end
                ST_NEXT_PULSE: begin
                    OAES_NEXT <= 1'b0;
                    r_timer   <= TMR_W'(TMR_LOAD);
                    r_state   <= ST_NEXT_WAIT;
                end
                ST_INIT_WAIT, ST_NEXT_WAIT: begin
                    if (w_holdoff) begin
                        r_timer <= r_timer - 1'b1;
                    end else if (w_ready_ok) begin
                        if (r_state == ST_INIT_WAIT) begin
                            r_state   <= ST_NEXT_PULSE;
                            OAES_NEXT <= 1'b1;
                        end else begin
                            r_state <= ST_CHECK;
                        end
                    end else if (w_timer_tc) begin
                        // A hung core aborts the remaining vectors
                        OTIMEOUT <= 1'b1;
                        OERR_CNT <= w_err_next;
                        if (OERR_CNT == '0) begin
                            OFAIL_IDX <= r_idx;
                        end
                        r_state <= ST_DONE;
                        OBUSY   <= 1'b0;
                        ODONE   <= 1'b1;
                        OPASS   <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (w_mismatch) begin
                        OERR_CNT <= w_err_next;
                        if (OERR_CNT == '0) begin
                            OFAIL_IDX <= r_idx;
                        end
                    end
                    if (w_last) begin
                        r_state <= ST_DONE;
                        OBUSY   <= 1'b0;
                        ODONE   <= 1'b1;
                        OPASS   <= !w_mismatch && (OERR_CNT == '0) && !OTIMEOUT;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= ST_FETCH;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_kat_bist.sv
// Directed bench for aes_kat_bist with a behavioural AES core model answering FIPS-197 vectors.
module tb_aes_kat_bist;

    localparam int NV    = 4;
    localparam int TMO   = 256;
    localparam int HO    = 2;
    localparam int TINIT = 3;
    localparam int TNEXT = 4;

    localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K256  =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, start1;
    logic         busy, done, pass, tmo, aes_enc, aes_init, aes_next, aes_kl;
    logic [2:0]   err_cnt;
    logic [1:0]   fail_idx;
    logic [255:0] aes_key;
    logic [127:0] aes_blk;
    logic         ready, valid;
    logic [127:0] result;

    logic         busy1, done1, pass1, tmo1, enc1, init1, next1, kl1;
    logic [0:0]   err1, fidx1;
    logic [255:0] key1;
    logic [127:0] blk1;

    aes_kat_bist #(.NUM_VECTORS(NV), .TIMEOUT_CYCLES(TMO), .HOLDOFF(HO)) u_dut (
        .ICLK(clk), .IRST(rst), .ISTART(start),
        .OBUSY(busy), .ODONE(done), .OPASS(pass), .OTIMEOUT(tmo),
        .OERR_CNT(err_cnt), .OFAIL_IDX(fail_idx),
        .OAES_ENCDEC(aes_enc), .OAES_INIT(aes_init), .OAES_NEXT(aes_next),
        .IAES_READY(ready), .OAES_KEY(aes_key), .OAES_KEYLEN(aes_kl),
        .OAES_BLOCK(aes_blk), .IAES_RESULT(result), .IAES_RESULT_VALID(valid)
    );

    aes_kat_bist #(.NUM_VECTORS(1), .TIMEOUT_CYCLES(TMO), .HOLDOFF(HO)) u_dut1 (
        .ICLK(clk), .IRST(rst), .ISTART(start1),
        .OBUSY(busy1), .ODONE(done1), .OPASS(pass1), .OTIMEOUT(tmo1),
        .OERR_CNT(err1), .OFAIL_IDX(fidx1),
        .OAES_ENCDEC(enc1), .OAES_INIT(init1), .OAES_NEXT(next1),
        .IAES_READY(1'b1), .OAES_KEY(key1), .OAES_KEYLEN(kl1),
        .OAES_BLOCK(blk1), .IAES_RESULT(CT128), .IAES_RESULT_VALID(1'b1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] ref_aes(input logic enc, input logic kl,
                                             input logic [255:0] key, input logic [127:0] blk);
        if (!kl && key == K128) begin
            if (enc && blk == PT)     return CT128;
            if (!enc && blk == CT128) return PT;
        end
        if (kl && key == K256) begin
            if (enc && blk == PT)     return CT256;
            if (!enc && blk == CT256) return PT;
        end
        return 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    endfunction

    // Core model: ready drops on a pulse and returns after a fixed latency
    logic flip_mode = 1'b0;
    logic hang_mode = 1'b0;
    int   core_cnt  = 0;
    logic op_next   = 1'b0;
    int   init_cnt  = 0;
    int   next_cnt  = 0;
    int   wide_cnt  = 0;
    logic init_q    = 1'b0;
    logic next_q    = 1'b0;
    logic [255:0] init_key [0:7];
    logic [127:0] next_blk [0:7];
    logic [1:0]   next_mode [0:7];

    always @(posedge clk) begin
        if (rst) begin
            ready    <= 1'b1;
            valid    <= 1'b0;
            result   <= '0;
            core_cnt <= 0;
            op_next  <= 1'b0;
        end else if (aes_init) begin
            ready    <= 1'b0;
            valid    <= 1'b0;
            op_next  <= 1'b0;
            core_cnt <= TINIT;
        end else if (aes_next) begin
            ready    <= 1'b0;
            valid    <= 1'b0;
            op_next  <= 1'b1;
            core_cnt <= (hang_mode && next_cnt == 1) ? 0 : TNEXT;
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                ready <= 1'b1;
                if (op_next) begin
                    valid  <= 1'b1;
                    result <= ref_aes(aes_enc, aes_kl, aes_key, aes_blk)
                              ^ {127'b0, flip_mode && aes_kl && aes_enc};
                end
            end
        end
    end

    always @(posedge clk) begin
        init_q <= aes_init;
        next_q <= aes_next;
        if (start && !busy) begin
            init_cnt <= 0;
            next_cnt <= 0;
            wide_cnt <= 0;
        end else begin
            if (aes_init) begin
                if (init_cnt < 8) init_key[init_cnt] <= aes_key;
                init_cnt <= init_cnt + 1;
            end
            if (aes_next) begin
                if (next_cnt < 8) begin
                    next_blk[next_cnt]  <= aes_blk;
                    next_mode[next_cnt] <= {aes_enc, aes_kl};
                end
                next_cnt <= next_cnt + 1;
            end
            if ((aes_init && init_q) || (aes_next && next_q)) wide_cnt <= wide_cnt + 1;
        end
    end

    task automatic pulse_start(input bit which);
        @(negedge clk);
        if (which) start1 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, done, 1);
    endtask

    task automatic wait_next_cnt(input int target, input string tag);
        int n = 0;
        while (next_cnt != target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_next_seen"}, next_cnt, target);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_tmo"}, tmo, 0);
        chk({tag, "_err"}, err_cnt, 0);
        chk({tag, "_fidx"}, fail_idx, 0);
        chk({tag, "_pulses"}, {aes_init, aes_next}, 0);
        chk({tag, "_key"}, aes_key, 0);
        chk({tag, "_blk"}, aes_blk, 0);
        chk({tag, "_mode"}, {aes_enc, aes_kl}, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_all_zero("reset");

        // clean run, including the per-pulse bus contents
        pulse_start(0);
        chk("run1_busy", busy, 1);
        wait_done("run1");
        chk("run1_pass", pass, 1);
        chk("run1_err", err_cnt, 0);
        chk("run1_tmo", tmo, 0);
        chk("run1_fidx", fail_idx, 0);
        chk("run1_inits", init_cnt, 2);
        chk("run1_nexts", next_cnt, 4);
        chk("run1_width", wide_cnt, 0);
        chk("run1_key0", init_key[0], K128);
        chk("run1_key1", init_key[1], K256);
        chk("run1_blk0", next_blk[0], PT);
        chk("run1_blk1", next_blk[1], CT128);
        chk("run1_blk2", next_blk[2], PT);
        chk("run1_blk3", next_blk[3], CT256);
        chk("run1_mode", {next_mode[0], next_mode[1], next_mode[2], next_mode[3]}, 8'b10_00_11_01);

        // restart from DONE, then a start pulse mid-test that must be ignored
        pulse_start(0);
        chk("run2_clear", {done, pass, busy}, 3'b001);
        repeat (10) @(negedge clk);
        pulse_start(0);
        wait_done("run2");
        chk("run2_pass", pass, 1);
        chk("run2_err", err_cnt, 0);
        chk("run2_inits", init_cnt, 2);
        chk("run2_nexts", next_cnt, 4);

        // corrupted result on vector 2
        flip_mode = 1'b1;
        pulse_start(0);
        wait_done("flip");
        chk("flip_err", err_cnt, 1);
        chk("flip_fidx", fail_idx, 2);
        chk("flip_pass", pass, 0);
        chk("flip_tmo", tmo, 0);
        chk("flip_nexts", next_cnt, 4);
        flip_mode = 1'b0;

        // core hangs after the second next pulse
        hang_mode = 1'b1;
        pulse_start(0);
        wait_next_cnt(2, "hang");
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!tmo && n < 1000);
        chk("hang_latency", n, HO + TMO);
        wait_done("hang");
        chk("hang_tmo", tmo, 1);
        chk("hang_err", err_cnt, 1);
        chk("hang_pass", pass, 0);
        chk("hang_nexts", next_cnt, 2);
        hang_mode = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // reset while vector 1 waits for its result
        pulse_start(0);
        wait_next_cnt(2, "abort");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero("abort");
        pulse_start(0);
        wait_done("abort_rerun");
        chk("abort_rerun_pass", pass, 1);
        chk("abort_rerun_err", err_cnt, 0);
        chk("abort_rerun_nexts", next_cnt, 4);

        // single-vector instance with ready stuck high: holdoff must be honoured
        pulse_start(1);
        n = 0;
        while (!init1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("nv1_init_seen", init1, 1);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!next1 && n < 100);
        chk("nv1_init_to_next", n, HO + 2);
        n = 0;
        while (!done1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("nv1_done", done1, 1);
        chk("nv1_pass", pass1, 1);
        chk("nv1_err", err1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_kat_bist.md
Name: aes_kat_bist

Overview:
- Synthesizable, parametrised known-answer-test (KAT) engine that drives the AES core's init/next/ready interface from an internal vector ROM.
- Self-checks each result, counts errors and detects hangs.
- Sits beside the AES core in the GCM datapath as a power-on/on-demand self-test.
- Generalises the single-vector directed encipher check:
  - N vectors, mixed encipher/decipher, mixed 128/256-bit keys;
  - optional key-reuse (skip re-init);
  - per-operation timeout.

Parameters:
- NUM_VECTORS, 4, number of ROM entries run per test; legal range 1..64.
- TIMEOUT_CYCLES, 256, max cycles waiting for IAES_READY per operation.
- HOLDOFF, 2, cycles after an init/next pulse before IAES_READY is sampled.
- IDX_W, $clog2(NUM_VECTORS) (min 1), vector index width.
- CNT_W, $clog2(NUM_VECTORS+1), error counter width.

Ports:
- ICLK  in  1  clock.
- IRST  in  1  synchronous active-high reset.
- ISTART  in  1  start self-test; level sampled in IDLE/DONE only.
- OBUSY  out  1  test in progress.
- ODONE  out  1  test finished; held until next ISTART or IRST.
- OPASS  out  1  valid with ODONE: 1 = zero errors and no timeout.
- OTIMEOUT  out  1  sticky; an operation exceeded TIMEOUT_CYCLES.
- OERR_CNT  out  CNT_W  number of mismatching vectors.
- OFAIL_IDX  out  IDX_W  index of first failing vector; 0 if none.
- OAES_ENCDEC  out  1  1 = encipher, 0 = decipher.
- OAES_INIT  out  1  key-expansion start pulse.
- OAES_NEXT  out  1  block-operation start pulse.
- IAES_READY  in  1  core ready.
- OAES_KEY  out  256  key; 128-bit keys in [255:128], [127:0] zero.
- OAES_KEYLEN  out  1  0 = 128-bit, 1 = 256-bit.
- OAES_BLOCK  out  128  input block.
- IAES_RESULT  in  128  core result.
- IAES_RESULT_VALID  in  1  result valid.

Behaviour:
Reset values:
- All outputs 0. FSM in IDLE; index, counters and flags cleared.
- IRST mid-test aborts immediately; OAES_INIT and OAES_NEXT deassert the same cycle.

FSM states:
- IDLE: on ISTART go to FETCH with idx=0; clear OERR_CNT, OTIMEOUT, OFAIL_IDX, ODONE, OPASS.
- FETCH (1 cycle): register ROM entry {encdec, keylen, reuse_key, key, pt, ct}; drive OAES_* from the registers; inputs are stable for the whole vector.
- Key reuse: if reuse_key=1 and idx!=0, go to NEXT_PULSE; otherwise go to INIT_PULSE.
- INIT_PULSE: OAES_INIT=1 for exactly 1 cycle, then INIT_WAIT.
- INIT_WAIT: ignore IAES_READY for HOLDOFF cycles, then go to NEXT_PULSE on IAES_READY=1.
- NEXT_PULSE: OAES_NEXT=1 for 1 cycle, then NEXT_WAIT.
- NEXT_WAIT: same holdoff, then go to CHECK on IAES_READY=1 with IAES_RESULT_VALID=1.
- CHECK (1 cycle): compare IAES_RESULT to the expected block.
  - Expected = ct for encipher, pt for decipher; ROM stores pt/ct in encipher orientation; on decipher, OAES_BLOCK=ct.
  - Mismatch: OERR_CNT += 1; on the first mismatch only, latch OFAIL_IDX=idx.
  - If idx==NUM_VECTORS-1 go to DONE; otherwise idx+1 and go to FETCH.
- DONE: OBUSY=0, ODONE=1, OPASS=(OERR_CNT==0)&&!OTIMEOUT. A new ISTART restarts the test as from IDLE.

Timeout:
- Per-wait cycle counter, reset on each pulse.
- On reaching TIMEOUT_CYCLES in either WAIT state: set OTIMEOUT, count it as an error for that vector, go to DONE (remaining vectors are skipped).

Handshake and timing:
- OBUSY=1 in every state except IDLE and DONE.
- ISTART while busy is ignored.
- IAES_READY=1 with RESULT_VALID=0 after holdoff in NEXT_WAIT keeps waiting, subject to timeout.
- OERR_CNT saturates at its maximum (cannot overflow for legal NUM_VECTORS).
- Latency per vector with full re-init: 1+1+HOLDOFF+Tinit+1+HOLDOFF+Tnext+1 cycles.

Decomposition:
- Shared package aes_kat_pkg:
  - vector struct {encdec, keylen, reuse_key, key[255:0], pt[127:0], ct[127:0]};
  - FSM state enum;
  - KEYLEN_128/256 and ENC/DEC constants;
  - FIPS-197 vector constants.
- Sub-module aes_kat_rom: combinational, indexed by idx, returns the struct; entries beyond the table wrap modulo the table size.
- Default table:
  - 0 = AES-128 enc: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, ct 69c4e0d86a7b0430d8cdb78070b4c55a.
  - 1 = same vector, decipher, reuse_key=1.
  - 2 = AES-256 enc: key 000102…1e1f, same pt, ct 8ea2b7ca516745bfeafc49904b496089.
  - 3 = vector 2, decipher, reuse_key=1.

Test Plan:
- With the real AES core, IRST 2 cycles, ISTART 1 cycle -> ODONE=1, OPASS=1, OERR_CNT=0, OTIMEOUT=0. Exactly 2 OAES_INIT pulses and 4 OAES_NEXT pulses, each 1 cycle wide.
- Core model flips bit 0 of the result for vector 2 (expects 8ea2b7ca516745bfeafc49904b496088 returned) -> OERR_CNT=1, OFAIL_IDX=2, OPASS=0; vector 3 still executed.
- Core model holds IAES_READY=0 after the second NEXT pulse -> OTIMEOUT=1 exactly TIMEOUT_CYCLES after holdoff end; DONE reached; OERR_CNT=1, OPASS=0.
- IRST asserted during NEXT_WAIT of vector 1 -> next cycle all outputs 0, FSM in IDLE; a following ISTART passes cleanly with OERR_CNT=0.
- ISTART re-pulsed mid-test -> ignored, pulse counts unchanged. ISTART in DONE -> flags cleared, full rerun passes.
- NUM_VECTORS=1, core keeps IAES_READY=1 during holdoff -> no early advance; first ready sample occurs HOLDOFF cycles after the INIT pulse.
